imem_loader: RTL

- Boot-time program loader that sits directly upstream of the pipelined core's fetch stage.
- Receives a byte stream (length header, instruction words, checksum), assembles 32-bit little-endian words and writes them into instruction memory.
- Holds the core in reset until a complete, checksum-valid image is loaded, then releases it.
- Can reload on request; on any load fault it keeps the core in reset and reports an error code.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_timeout.sv | 36 +++
 rtl/imem_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BITS       = 16;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    WORD,
    CHECK,
    RUN,
    ERROR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CKSUM   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

endpackage

// File: rtl/imem_loader_timeout.sv
// Inter-byte idle counter; expired flags the cycle in which the count steps
// onto TIMEOUT_CYCLES-1, so the caller can act on the same clock edge.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == CW'(TIMEOUT_CYCLES - 2));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/words/checksum byte stream into instruction
// memory and holds the core in reset until a valid image is present.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int NUM_INST       = 128,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int IADDR_BITS     = $clog2(NUM_INST)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic                  load_req,
  output logic                  imem_we,
  output logic [IADDR_BITS-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rstn,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  state_e                state_q, state_d;
  err_code_e             err_code_q, err_code_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic [IADDR_BITS-1:0] addr_q, addr_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           word_q, word_d;
  logic [7:0]            cksum_q, cksum_d;
  logic                  we_q, we_d;
  logic [IADDR_BITS-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                accept;
  logic                expired;
  logic                timer_en;
  logic [LEN_BITS-1:0] len_full;
  logic                len_bad;
  logic                last_byte;
  logic                last_word;
  logic                cksum_ok;

  assign accept    = rx_valid && rx_ready;
  assign timer_en  = (state_q == LEN_HI) || (state_q == WORD) || (state_q == CHECK);
  assign len_full  = {rx_data, len_q[7:0]};
  assign len_bad   = (len_full == '0) || (len_full > LEN_BITS'(NUM_INST));
  assign last_byte = (idx_q == 2'(BYTES_PER_WORD - 1));
  assign last_word = (LEN_BITS'(addr_q) == (len_q - LEN_BITS'(1)));
  assign cksum_ok  = (rx_data == cksum_q);

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (accept || !timer_en),
    .en     (timer_en),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= LEN_LO;
    end else begin
      state_q <= state_d;
    end
  end

  // An accepted byte always takes priority over a simultaneous timer expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LEN_LO: begin
        if (accept) state_d = LEN_HI;
      end
      LEN_HI: begin
        if (accept)       state_d = len_bad ? ERROR : WORD;
        else if (expired) state_d = ERROR;
      end
      WORD: begin
        if (accept) begin
          if (last_byte && last_word) state_d = CHECK;
        end else if (expired) begin
          state_d = ERROR;
        end
      end
      CHECK: begin
        if (accept)       state_d = cksum_ok ? RUN : ERROR;
        else if (expired) state_d = ERROR;
      end
      RUN, ERROR: begin
        if (load_req) state_d = LEN_LO;
      end
      default: state_d = LEN_LO;
    endcase
  end

  always_comb begin
    rx_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    core_rstn = 1'b0;
    case (state_q)
      LEN_LO, LEN_HI, WORD, CHECK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      RUN: begin
        done      = 1'b1;
        core_rstn = 1'b1;
      end
      ERROR:   err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    len_d      = len_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    word_d     = word_q;
    cksum_d    = cksum_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    err_code_d = err_code_q;

    if (accept) begin
      case (state_q)
        LEN_LO: len_d = {8'h00, rx_data};
        LEN_HI: begin
          len_d   = len_full;
          addr_d  = '0;
          idx_d   = '0;
          cksum_d = '0;
          if (len_bad) err_code_d = ERR_LEN;
        end
        WORD: begin
          word_d[{idx_q, 3'b000} +: 8] = rx_data;
          cksum_d = cksum_q ^ rx_data;
          idx_d   = idx_q + 2'd1;
          if (last_byte) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = word_d;
            addr_d  = addr_q + IADDR_BITS'(1);
          end
        end
        CHECK: begin
          if (!cksum_ok) err_code_d = ERR_CKSUM;
        end
        default: ;
      endcase
    end else if (expired) begin
      err_code_d = ERR_TIMEOUT;
    end

    if (((state_q == RUN) || (state_q == ERROR)) && load_req) begin
      err_code_d = ERR_NONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q      <= '0;
      addr_q     <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      cksum_q    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      len_q      <= len_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      cksum_q    <= cksum_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      err_code_q <= err_code_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign err_code   = err_code_q;

endmodule
